// File: rtl/bin2bcd_4dig.sv
// Sequential shift-and-add-3 binary to 4-digit BCD converter.
// Saturates at 9999 with an overflow flag; outputs hold between conversions.
module bin2bcd_4dig #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       data0,
    output logic [3:0]       data1,
    output logic [3:0]       data2,
    output logic [3:0]       data3
);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    localparam logic [4:0] LAST = 5'(BIN_W - 1);

    state_t           state;
    logic [BIN_W-1:0] shift;
    logic [15:0]      scratch;
    logic [15:0]      adj;
    logic [15:0]      scr_nxt;
    logic [4:0]       cnt;
    logic             sat;
    logic [31:0]      bin_ext;

    assign bin_ext = {{(32 - BIN_W){1'b0}}, bin};

    // One double-dabble step: bump nibbles >= 5 by 3, then shift in next bit.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        scr_nxt = {adj[14:0], shift[BIN_W-1]};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            scratch <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            data0   <= '0;
            data1   <= '0;
            data2   <= '0;
            data3   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shift   <= bin;
                        scratch <= '0;
                        cnt     <= '0;
                        sat     <= (bin_ext > 32'd9999);
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    scratch <= scr_nxt;
                    shift   <= shift << 1;
                    cnt     <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (sat) begin
                            ovf   <= 1'b1;
                            data3 <= 4'd9;
                            data2 <= 4'd9;
                            data1 <= 4'd9;
                            data0 <= 4'd9;
                        end else begin
                            ovf   <= 1'b0;
                            data3 <= scr_nxt[15:12];
                            data2 <= scr_nxt[11:8];
                            data1 <= scr_nxt[7:4];
                            data0 <= scr_nxt[3:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_4dig.sv
// Bench for bin2bcd_4dig: cycle model of busy/done/outputs with a
// scoreboard queue of expected conversions, table vectors and corner cases.
module tb_bin2bcd_4dig;

    localparam int BIN_W = 14;

    logic             clk;
    logic             rst;
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       data0;
    logic [3:0]       data1;
    logic [3:0]       data2;
    logic [3:0]       data3;

    bin2bcd_4dig #(.BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .data0 (data0),
        .data1 (data1),
        .data2 (data2),
        .data3 (data3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        o;
        int          due;
    } exp_t;

    typedef struct {
        int          v;
        logic [15:0] d;
        logic        o;
    } vec_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          m_free = -1;
    logic        exp_done = 1'b0;
    logic [15:0] m_d = 16'h0;
    logic        m_o = 1'b0;
    logic [15:0] nxt_d = 16'h0;
    logic        nxt_o = 1'b0;

    function automatic logic [15:0] ref_bcd(input int v);
        int m;
        m = (v > 9999) ? 9999 : v;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // Cycle model: acceptance, completion and held output values.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                m_free = -1;
                exp_done = 1'b0;
                m_d = 16'h0;
                m_o = 1'b0;
            end else begin
                exp_done = 1'b0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    exp_done = 1'b1;
                    m_d = q[0].d;
                    m_o = q[0].o;
                    void'(q.pop_front());
                end
                if (start && cyc > m_free) begin
                    q.push_back('{d: nxt_d, o: nxt_o, due: cyc + BIN_W});
                    m_free = cyc + BIN_W;
                end
            end
        end
    end

    // Compare every output on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("busy", int'(busy), int'(cyc < m_free));
                check("done", int'(done), int'(exp_done));
                check("ovf", int'(ovf), int'(m_o));
                check("data", int'({data3, data2, data1, data0}), int'(m_d));
            end
        end
    end

    task automatic drive(input int v, input logic [15:0] d, input logic o);
        bin = BIN_W'(v);
        nxt_d = d;
        nxt_o = o;
        start = 1'b1;
    endtask

    task automatic convert(input int v, input logic [15:0] d, input logic o);
        @(posedge clk);
        #1 drive(v, d, o);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (BIN_W + 2) @(posedge clk);
    endtask

    vec_t vecs[6];

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bin = '0;
        vecs[0] = '{1234, 16'h1234, 1'b0};
        vecs[1] = '{0, 16'h0000, 1'b0};
        vecs[2] = '{9999, 16'h9999, 1'b0};
        vecs[3] = '{10000, 16'h9999, 1'b1};
        vecs[4] = '{16383, 16'h9999, 1'b1};
        vecs[5] = '{7, 16'h0007, 1'b0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 6; i++)
            convert(vecs[i].v, vecs[i].d, vecs[i].o);
        repeat (5) @(posedge clk);

        // start while busy is ignored; start in the done cycle is taken
        @(posedge clk);
        #1 drive(42, 16'h0042, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 drive(999, 16'h0999, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #1 drive(999, 16'h0999, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (BIN_W + 3) @(posedge clk);

        // reset mid-conversion aborts, then restart
        @(posedge clk);
        #1 drive(5678, 16'h5678, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        convert(5678, 16'h5678, 1'b0);

        // random sweep against the reference digits
        for (int i = 0; i < 40; i++) begin
            int v;
            v = int'($urandom_range(0, 16383));
            convert(v, ref_bcd(v), v > 9999);
        end

        repeat (BIN_W + 2) @(posedge clk);
        check("pending", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
